// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared FSM state, ASCII character and ALU encoding constants
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPA  = 3'd1,
    OPB  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CLR   = 8'h43;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  localparam logic OP_ADD      = 1'b0;
  localparam logic OP_SUB      = 1'b1;
  localparam logic DT_UNSIGNED = 1'b0;
  localparam logic DT_SIGNED   = 1'b1;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

endpackage

`default_nettype wire

// File: rtl/expr_parser_if.sv
// ============================================================================
// expr_parser_if : character stream in, ALU operand/control bundle out
// Optional echo signals exist only when PARSER_ECHO_EN is defined.
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

interface expr_parser_if #(
  parameter int W = 32
);
  logic [7:0]   char_in;
  logic         char_valid;
  logic         char_ready;
  logic         alu_done;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         operator;
  logic         data_type;
  logic         parser_done;
  logic         parse_err;
`ifdef PARSER_ECHO_EN
  logic [7:0]   echo_char;
  logic         echo_valid;
`endif

  // Parser side
  modport slave (
    input  char_in, char_valid, alu_done,
`ifdef PARSER_ECHO_EN
    output echo_char, echo_valid,
`endif
    output char_ready, a, b, operator, data_type, parser_done, parse_err
  );

  // Character source / ALU side
  modport master (
    output char_in, char_valid, alu_done,
`ifdef PARSER_ECHO_EN
    input  echo_char, echo_valid,
`endif
    input  char_ready, a, b, operator, data_type, parser_done, parse_err
  );

endinterface

`default_nettype wire

// File: rtl/expr_parser_dec_accum.sv
// ============================================================================
// dec_accum : decimal operand accumulator with digit counter and
//             look-ahead overflow flag for the digit currently offered
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module dec_accum #(
  parameter int W          = 32,
  parameter int MAX_DIGITS = 10
) (
  input  wire logic         clk,
  input  wire logic         n_rst,
  input  wire logic         clr_i,
  input  wire logic         load_i,
  input  wire logic         step_i,
  input  wire logic [3:0]   digit_i,
  output logic [W-1:0]      acc_o,
  output logic              has_digit_o,
  output logic              ovf_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] ndig_q, ndig_d;
  logic [W+3:0]  prod_w;

  // Ten times a W-bit value plus a digit always fits in W+4 bits
  assign prod_w = ({4'b0000, acc_q} * (W+4)'(10)) + (W+4)'(digit_i);

  assign ovf_o       = (prod_w[W+3:W] != 4'b0000) || (ndig_q == CW'(MAX_DIGITS));
  assign has_digit_o = (ndig_q != '0);
  assign acc_o       = acc_q;

  always_comb begin
    acc_d  = acc_q;
    ndig_d = ndig_q;
    if (clr_i) begin
      acc_d  = '0;
      ndig_d = '0;
    end else if (load_i) begin
      acc_d  = W'(digit_i);
      ndig_d = CW'(1);
    end else if (step_i) begin
      acc_d  = prod_w[W-1:0];
      ndig_d = ndig_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q  <= '0;
      ndig_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ndig_q <= ndig_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/expr_parser.sv
// ============================================================================
// expr_parser : parses "A op B =" from an ASCII stream into ALU operands
// Optional PARSER_ECHO_EN adds a one-cycle-delayed echo of accepted characters.
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module expr_parser
  import calc_pkg::*;
#(
  parameter int W          = 32,
  parameter int MAX_DIGITS = 10
) (
  input  wire logic     clk,
  input  wire logic     n_rst,
  expr_parser_if.slave  bus
);

  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  state_e       state_q, state_d;
  logic         sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic         op_pend_q, op_pend_d;
  logic [W-1:0] a_q, b_q;
  logic         op_q, dt_q;

  logic         accept_w, is_clr_w, is_space_w, is_dig_w;
  logic [7:0]   ch_w;
  logic         clr_acc_w, ld_a_w, st_a_w, st_b_w, latch_w;
  logic [W-1:0] acc_a_w, acc_b_w;
  logic         has_a_w, has_b_w, ovf_a_w, ovf_b_w;
  logic         dt_w, ok_a_w, ok_b_w, range_ok_w;

  assign ch_w       = bus.char_in;
  assign accept_w   = bus.char_valid && bus.char_ready;
  assign is_clr_w   = (ch_w == CH_CLR) || (ch_w == CH_ESC);
  assign is_space_w = (ch_w == CH_SPACE);
  assign is_dig_w   = is_digit(ch_w);

  dec_accum #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk         (clk),
    .n_rst       (n_rst),
    .clr_i       (clr_acc_w),
    .load_i      (ld_a_w),
    .step_i      (st_a_w),
    .digit_i     (ch_w[3:0]),
    .acc_o       (acc_a_w),
    .has_digit_o (has_a_w),
    .ovf_o       (ovf_a_w)
  );

  dec_accum #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk         (clk),
    .n_rst       (n_rst),
    .clr_i       (clr_acc_w),
    .load_i      (1'b0),
    .step_i      (st_b_w),
    .digit_i     (ch_w[3:0]),
    .acc_o       (acc_b_w),
    .has_digit_o (has_b_w),
    .ovf_o       (ovf_b_w)
  );

  // Range limits only apply once either operand is signed
  assign dt_w       = sign_a_q | sign_b_q;
  assign ok_a_w     = sign_a_q ? (acc_a_w <= HALF) : (acc_a_w < HALF);
  assign ok_b_w     = sign_b_q ? (acc_b_w <= HALF) : (acc_b_w < HALF);
  assign range_ok_w = !dt_w || (ok_a_w && ok_b_w);

  always_comb begin
    state_d   = state_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    op_pend_d = op_pend_q;
    ld_a_w    = 1'b0;
    st_a_w    = 1'b0;
    st_b_w    = 1'b0;
    latch_w   = 1'b0;

    if (accept_w) begin
      if (is_clr_w) begin
        state_d = IDLE;
      end else if (!is_space_w) begin
        unique case (state_q)
          IDLE: begin
            if (ch_w == CH_MINUS) begin
              sign_a_d = 1'b1;
              state_d  = OPA;
            end else if (is_dig_w) begin
              ld_a_w  = 1'b1;
              state_d = OPA;
            end else begin
              state_d = ERR;
            end
          end
          OPA: begin
            if (is_dig_w) begin
              if (ovf_a_w) state_d = ERR;
              else         st_a_w  = 1'b1;
            end else if (((ch_w == CH_PLUS) || (ch_w == CH_MINUS)) && has_a_w) begin
              op_pend_d = (ch_w == CH_MINUS) ? OP_SUB : OP_ADD;
              state_d   = OPB;
            end else begin
              state_d = ERR;
            end
          end
          OPB: begin
            if (is_dig_w) begin
              if (ovf_b_w) state_d = ERR;
              else         st_b_w  = 1'b1;
            end else if ((ch_w == CH_MINUS) && !has_b_w && !sign_b_q) begin
              sign_b_d = 1'b1;
            end else if ((ch_w == CH_EQ) && has_b_w) begin
              if (range_ok_w) begin
                latch_w = 1'b1;
                state_d = DONE;
              end else begin
                state_d = ERR;
              end
            end else begin
              state_d = ERR;
            end
          end
          ERR: begin
            if (ch_w == CH_EQ) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end

    if ((state_q == DONE) && bus.alu_done) state_d = IDLE;

    if (state_d == IDLE) begin
      sign_a_d = 1'b0;
      sign_b_d = 1'b0;
    end
  end

  assign clr_acc_w = (state_d == IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      op_pend_q <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      dt_q      <= DT_UNSIGNED;
    end else begin
      state_q   <= state_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      op_pend_q <= op_pend_d;
      if (latch_w) begin
        a_q  <= sign_a_q ? -acc_a_w : acc_a_w;
        b_q  <= sign_b_q ? -acc_b_w : acc_b_w;
        op_q <= op_pend_q;
        dt_q <= dt_w ? DT_SIGNED : DT_UNSIGNED;
      end
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.operator    = op_q;
  assign bus.data_type   = dt_q;
  assign bus.parser_done = (state_q == DONE);
  assign bus.parse_err   = (state_q == ERR);
  assign bus.char_ready  = (state_q != DONE);

`ifdef PARSER_ECHO_EN
  logic [7:0] echo_char_q;
  logic       echo_valid_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      echo_char_q  <= 8'h00;
      echo_valid_q <= 1'b0;
    end else begin
      echo_valid_q <= accept_w && (state_q != ERR);
      if (accept_w && (state_q != ERR)) echo_char_q <= ch_w;
    end
  end

  assign bus.echo_char  = echo_char_q;
  assign bus.echo_valid = echo_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_expr_parser.sv
// ============================================================================
// tb_expr_parser : directed stimulus with scoreboard queue and negedge monitor
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_expr_parser;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  expr_parser_if #(.W(32)) bus();

  expr_parser #(.W(32), .MAX_DIGITS(10)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        dt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_ok(input logic [31:0] a, input logic [31:0] b, input logic op, input logic dt);
    exp_t e;
    e.is_err = 1'b0; e.a = a; e.b = b; e.op = op; e.dt = dt;
    sb.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1; e.a = '0; e.b = '0; e.op = 1'b0; e.dt = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: every rising parser_done / parse_err consumes one scoreboard entry
  always @(negedge clk) begin
    if (bus.parser_done && !prev_done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("kind_done", {31'b0, mon_e.is_err}, 32'd0);
        if (!mon_e.is_err) begin
          chk("a", bus.a, mon_e.a);
          chk("b", bus.b, mon_e.b);
          chk("operator", {31'b0, bus.operator}, {31'b0, mon_e.op});
          chk("data_type", {31'b0, bus.data_type}, {31'b0, mon_e.dt});
        end
      end
    end
    if (bus.parse_err && !prev_err) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got parse_err with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("kind_err", {31'b0, mon_e.is_err}, 32'd1);
      end
    end
    prev_done = bus.parser_done;
    prev_err  = bus.parse_err;
  end

  task automatic send(input byte c);
    int n = 0;
    @(negedge clk);
    while (!bus.char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: char_ready low for %0d cycles, required 1", n);
    end
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1 bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic pulse_alu_done();
    @(negedge clk);
    bus.alu_done = 1'b1;
    @(posedge clk);
    #1 bus.alu_done = 1'b0;
    chk("done_after_alu", {31'b0, bus.parser_done}, 32'd0);
    chk("ready_after_alu", {31'b0, bus.char_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a"}, bus.a, 32'd0);
    chk({tag, "_b"}, bus.b, 32'd0);
    chk({tag, "_op"}, {31'b0, bus.operator}, 32'd0);
    chk({tag, "_dt"}, {31'b0, bus.data_type}, 32'd0);
    chk({tag, "_done"}, {31'b0, bus.parser_done}, 32'd0);
    chk({tag, "_err"}, {31'b0, bus.parse_err}, 32'd0);
    chk({tag, "_ready"}, {31'b0, bus.char_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.alu_done   = 1'b0;
    n_rst          = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(negedge clk);
    n_rst = 1'b1;

    // Basic subtract, latency, hold and release
    exp_ok(32'd123, 32'd456, 1'b1, 1'b0);
    send_str("123-456=");
    chk("done_latency", {31'b0, bus.parser_done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("done_held", {31'b0, bus.parser_done}, 32'd1);
    chk("ready_in_done", {31'b0, bus.char_ready}, 32'd0);
    pulse_alu_done();
    chk("a_kept", bus.a, 32'd123);

    // Signed operand with spaces
    exp_ok(32'hFFFF_FFFB, 32'd7, 1'b0, 1'b1);
    send_str("-5 + 7=");
    pulse_alu_done();

    // Value overflow on the 10th digit, recovery via '='
    exp_err();
    send_str("429496729");
    chk("no_err_9_digits", {31'b0, bus.parse_err}, 32'd0);
    send("6");
    chk("err_10th_digit", {31'b0, bus.parse_err}, 32'd1);
    send_str("+1=");
    chk("err_cleared_eq", {31'b0, bus.parse_err}, 32'd0);
    exp_ok(32'd1, 32'd1, 1'b0, 1'b0);
    send_str("1+1=");
    pulse_alu_done();

    // Illegal operator
    exp_err();
    send_str("12*");
    chk("err_at_star", {31'b0, bus.parse_err}, 32'd1);
    send_str("3=");
    chk("err_cleared_star", {31'b0, bus.parse_err}, 32'd0);

    // Range check boundaries
    exp_ok(32'h8000_0000, 32'd0, 1'b0, 1'b1);
    send_str("-2147483648+0=");
    pulse_alu_done();
    exp_err();
    send_str("2147483648+-1=");
    chk("err_range", {31'b0, bus.parse_err}, 32'd1);
    send(8'h43);
    chk("err_cleared_C", {31'b0, bus.parse_err}, 32'd0);

    // Async reset mid-expression
    send_str("77+");
    #2 n_rst = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(negedge clk);
    n_rst = 1'b1;

    // Clear mid-expression
    send_str("88+");
    send(8'h43);
    exp_ok(32'd1, 32'd1, 1'b1, 1'b0);
    send_str("1-1=");
    pulse_alu_done();

    // char_valid held during DONE must not be consumed
    exp_ok(32'd2, 32'd3, 1'b0, 1'b0);
    send_str("2+3=");
    @(negedge clk);
    bus.char_in    = 8'h39;
    bus.char_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_ready", {31'b0, bus.char_ready}, 32'd0);
    chk("hold_done", {31'b0, bus.parser_done}, 32'd1);
    chk("hold_a", bus.a, 32'd2);
    bus.char_valid = 1'b0;
    pulse_alu_done();

    // alu_done while in OPA is ignored
    exp_ok(32'd6, 32'd4, 1'b0, 1'b0);
    send("6");
    pulse_alu_done();
    send_str("+4=");
    pulse_alu_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
